// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared constants and FSM state type for the 8N1 UART core.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    localparam int OVERSAMPLE = 16;
    localparam int DATA_BITS  = 8;
    localparam int HALF_BIT   = 8;
    localparam int UBRR_W     = 12;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_e;

endpackage
`default_nettype wire

// File: rtl/uart_baud_gen.sv
`default_nettype none
// ============================================================================
// Module      : uart_baud_gen
// Description : 12-bit baud divisor producing a one-cycle 16x oversample tick.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_baud_gen
    import uart_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [UBRR_W-1:0] ubrr,
    output logic              tick
);

    logic [UBRR_W-1:0] r_count;

    // ">=" lets a divisor lowered mid-count wrap at once instead of rolling over
    assign tick = (r_count >= ubrr);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (tick) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_core.sv
`default_nettype none
// ============================================================================
// Module      : uart_core
// Description : 8N1 UART engine; static mode selects continuous TX or RX.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_core
    import uart_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic [UBRR_W-1:0]    ubrr,
    input  logic                 mode,
    input  logic [DATA_BITS-1:0] data_i,
    output logic [DATA_BITS-1:0] data_o,
    input  logic                 rxd,
    output logic                 txd
);

    localparam int         c_bit_w     = $clog2(DATA_BITS);
    localparam logic [3:0] c_last_tick = 4'(OVERSAMPLE - 1);
    localparam logic [3:0] c_half_tick = 4'(HALF_BIT - 1);
    localparam logic [c_bit_w-1:0] c_last_bit = c_bit_w'(DATA_BITS - 1);

    logic w_tick;

    uart_state_e            r_tx_state, w_tx_state;
    logic [DATA_BITS-1:0]   r_tx_shift, w_tx_shift;
    logic [3:0]             r_tx_tick,  w_tx_tick;
    logic [c_bit_w-1:0]     r_tx_bit,   w_tx_bit;

    uart_state_e            r_rx_state, w_rx_state;
    logic [DATA_BITS-1:0]   r_rx_shift, w_rx_shift;
    logic [3:0]             r_rx_tick,  w_rx_tick;
    logic [c_bit_w-1:0]     r_rx_bit,   w_rx_bit;
    logic [DATA_BITS-1:0]   r_data_o,   w_data_o;
    logic [1:0]             r_rx_sync;
    logic                   w_rxd;

    uart_baud_gen u_baud_gen (
        .clk  (clk),
        .rst  (rst),
        .ubrr (ubrr),
        .tick (w_tick)
    );

    assign w_rxd  = r_rx_sync[1];
    assign data_o = r_data_o;
    assign txd    = (r_tx_state == START) ? 1'b0 :
                    (r_tx_state == DATA)  ? r_tx_shift[0] : 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_tx_state <= IDLE;
            r_tx_shift <= '0;
            r_tx_tick  <= '0;
            r_tx_bit   <= '0;
            r_rx_state <= IDLE;
            r_rx_shift <= '0;
            r_rx_tick  <= '0;
            r_rx_bit   <= '0;
            r_data_o   <= '0;
            r_rx_sync  <= 2'b11;
        end else begin
            r_tx_state <= w_tx_state;
            r_tx_shift <= w_tx_shift;
            r_tx_tick  <= w_tx_tick;
            r_tx_bit   <= w_tx_bit;
            r_rx_state <= w_rx_state;
            r_rx_shift <= w_rx_shift;
            r_rx_tick  <= w_rx_tick;
            r_rx_bit   <= w_rx_bit;
            r_data_o   <= w_data_o;
            r_rx_sync  <= {r_rx_sync[0], rxd};
        end
    end

    // Transmitter: STOP chains straight into the next START so frames are gapless
    always_comb begin
        w_tx_state = r_tx_state;
        w_tx_shift = r_tx_shift;
        w_tx_tick  = r_tx_tick;
        w_tx_bit   = r_tx_bit;
        if (!mode) begin
            w_tx_state = IDLE;
            w_tx_tick  = '0;
            w_tx_bit   = '0;
        end else if (w_tick) begin
            w_tx_tick = r_tx_tick + 4'd1;
            case (r_tx_state)
                IDLE: begin
                    w_tx_state = START;
                    w_tx_shift = data_i;
                    w_tx_tick  = '0;
                end
                START: begin
                    if (r_tx_tick == c_last_tick) begin
                        w_tx_state = DATA;
                        w_tx_bit   = '0;
                    end
                end
                DATA: begin
                    if (r_tx_tick == c_last_tick) begin
                        w_tx_shift = {1'b0, r_tx_shift[DATA_BITS-1:1]};
                        w_tx_bit   = r_tx_bit + 1'b1;
                        if (r_tx_bit == c_last_bit) begin
                            w_tx_state = STOP;
                        end
                    end
                end
                STOP: begin
                    if (r_tx_tick == c_last_tick) begin
                        w_tx_state = START;
                        w_tx_shift = data_i;
                    end
                end
                default: w_tx_state = IDLE;
            endcase
        end
    end

    // Receiver: START re-checks at mid-bit, after which each sample lands mid-bit
    always_comb begin
        w_rx_state = r_rx_state;
        w_rx_shift = r_rx_shift;
        w_rx_tick  = r_rx_tick;
        w_rx_bit   = r_rx_bit;
        w_data_o   = r_data_o;
        if (mode) begin
            w_rx_state = IDLE;
            w_rx_tick  = '0;
            w_rx_bit   = '0;
        end else if (w_tick) begin
            w_rx_tick = r_rx_tick + 4'd1;
            case (r_rx_state)
                IDLE: begin
                    w_rx_tick = '0;
                    if (!w_rxd) begin
                        w_rx_state = START;
                    end
                end
                START: begin
                    if (r_rx_tick == c_half_tick) begin
                        w_rx_tick  = '0;
                        w_rx_bit   = '0;
                        w_rx_state = w_rxd ? IDLE : DATA;
                    end
                end
                DATA: begin
                    if (r_rx_tick == c_last_tick) begin
                        w_rx_shift = {w_rxd, r_rx_shift[DATA_BITS-1:1]};
                        w_rx_bit   = r_rx_bit + 1'b1;
                        if (r_rx_bit == c_last_bit) begin
                            w_rx_state = STOP;
                        end
                    end
                end
                STOP: begin
                    if (r_rx_tick == c_last_tick) begin
                        w_rx_state = IDLE;
                        if (w_rxd) begin
                            w_data_o = r_rx_shift;
                        end
                    end
                end
                default: w_rx_state = IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_core.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_core
// Description : Scoreboard bench: TX instance looped into an RX instance.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_core;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [11:0] ubrr = 12'd23;
    logic        tx_mode = 1'b1;
    logic [7:0]  tx_data = 8'h00;
    logic        drv_rxd = 1'b1;
    logic        loop_en = 1'b0;
    logic        tx_txd, rx_txd, rx_rxd;
    logic [7:0]  tx_data_o, rx_data_o;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    logic [7:0] rx_exp_q[$];
    logic [7:0] last_rx = 8'h00;
    logic [7:0] rx_prev = 8'h00;
    logic [7:0] rx_exp;

    bit   tx_mon_en = 1'b0;
    bit   tx_have_prev = 1'b0;
    int   tx_frames = 0;
    int   tx_prev_start = 0;
    logic mon_last = 1'b1;
    bit   mon_ab;
    logic [7:0] mon_b;
    int   mon_p, mon_bad, mon_st;

    int k, n, p, gap, bad, base;
    logic [7:0] b;
    logic stop;

    assign rx_rxd = loop_en ? tx_txd : drv_rxd;

    uart_core u_tx (
        .clk    (clk),
        .rst    (rst),
        .ubrr   (ubrr),
        .mode   (tx_mode),
        .data_i (tx_data),
        .data_o (tx_data_o),
        .rxd    (1'b1),
        .txd    (tx_txd)
    );

    uart_core u_rx (
        .clk    (clk),
        .rst    (rst),
        .ubrr   (ubrr),
        .mode   (1'b0),
        .data_i (8'h00),
        .data_o (rx_data_o),
        .rxd    (rx_rxd),
        .txd    (rx_txd)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic check_true(input string name, input bit cond, input int act);
        n_tests++;
        if (!cond) begin
            n_fail++;
            $display("FAIL %s: observed %0d outside allowed range", name, act);
        end
    endtask

    // Line level of an 8N1 frame at bit slot k (0 = start, 1..8 = data, 9 = stop)
    function automatic logic frame_level(input logic [7:0] fb, input int slot);
        if (slot == 0)      return 1'b0;
        else if (slot <= 8) return fb[slot-1];
        else                return 1'b1;
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        last_rx = 8'h00;
        rx_exp_q.delete();
        rst = 1'b0;
    endtask

    task automatic send_rx(input logic [7:0] fb, input logic fstop, input int bp);
        logic [9:0] f;
        f = {fstop, fb, 1'b0};
        if (fstop && fb != last_rx) begin
            rx_exp_q.push_back(fb);
            last_rx = fb;
        end
        for (int i = 0; i < 10; i++) begin
            drv_rxd = f[i];
            repeat (bp) @(negedge clk);
        end
        drv_rxd = 1'b1;
    endtask

    // RX monitor: every change of data_o must match the next expected byte
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                rx_prev = rx_data_o;
            end else if (rx_data_o !== rx_prev) begin
                if (rx_exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL rx_unexpected: got %0h, expected no update", rx_data_o);
                end else begin
                    rx_exp = rx_exp_q.pop_front();
                    check_eq("rx_data", rx_data_o, rx_exp);
                end
                rx_prev = rx_data_o;
            end
        end
    end

    // TX monitor: checks txd every clock of a frame against data_i at frame start
    initial begin
        forever begin
            @(negedge clk);
            if (!tx_mon_en || rst) begin
                tx_have_prev = 1'b0;
            end else if (mon_last && !tx_txd) begin
                mon_p  = 16 * (int'(ubrr) + 1);
                mon_b  = tx_data;
                mon_st = cyc;
                mon_bad = 0;
                mon_ab = 1'b0;
                if (tx_have_prev) check_eq("tx_gap", mon_st - tx_prev_start, 10 * mon_p);
                tx_have_prev  = 1'b1;
                tx_prev_start = mon_st;
                for (int c = 1; c < 10 * mon_p; c++) begin
                    @(negedge clk);
                    if (!tx_mon_en || rst) begin
                        mon_ab = 1'b1;
                        break;
                    end
                    if (tx_txd !== frame_level(mon_b, c / mon_p)) mon_bad++;
                end
                if (!mon_ab) begin
                    check_eq("tx_frame_bad_clks", mon_bad, 0);
                    tx_frames++;
                end else begin
                    tx_have_prev = 1'b0;
                end
            end
            mon_last = tx_txd;
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset with arbitrary inputs
        repeat (3) begin
            @(negedge clk);
            check_eq("rst_tx_txd", tx_txd, 1'b1);
            check_eq("rst_rx_txd", rx_txd, 1'b1);
            check_eq("rst_data_o", rx_data_o, 8'h00);
            drv_rxd = 1'($urandom);
            tx_data = 8'($urandom);
        end

        // TX frames of 0x37 looped into the receiver, then 0x72 mid-frame
        tx_data   = 8'h37;
        drv_rxd   = 1'b1;
        loop_en   = 1'b1;
        tx_mon_en = 1'b1;
        rx_exp_q.push_back(8'h37);
        last_rx = 8'h37;
        rst = 1'b0;
        k = 0;
        do begin
            @(negedge clk);
            k++;
            if (k == 1) begin
                check_eq("release_txd", tx_txd, 1'b1);
                check_eq("release_data_o", rx_data_o, 8'h00);
            end
        end while (tx_txd !== 1'b0 && k < 100);
        check_true("tx_first_start", tx_txd === 1'b0 && k <= int'(ubrr) + 1, k);
        repeat (5760) @(negedge clk);
        tx_data = 8'h72;
        rx_exp_q.push_back(8'h72);
        last_rx = 8'h72;
        n = 0;
        while (rx_exp_q.size() != 0 && n < 8000) begin
            @(negedge clk);
            n++;
        end
        check_eq("loop_rx_pending", rx_exp_q.size(), 0);
        check_eq("loop_data_o", rx_data_o, 8'h72);
        check_true("tx_frames_seen", tx_frames >= 2, tx_frames);

        // Direct RX stimulus at 9600 baud
        tx_mon_en = 1'b0;
        tx_mode   = 1'b0;
        loop_en   = 1'b0;
        drv_rxd   = 1'b1;
        ubrr      = 12'd23;
        do_reset();
        repeat (50) @(negedge clk);
        send_rx(8'h48, 1'b1, 384);
        check_eq("rx48_pending", rx_exp_q.size(), 0);
        check_eq("rx48_data_o", rx_data_o, 8'h48);
        repeat (384) @(negedge clk);
        drv_rxd = 1'b0;
        repeat (72) @(negedge clk);
        drv_rxd = 1'b1;
        repeat (3840) @(negedge clk);
        check_eq("rx_glitch", rx_data_o, last_rx);
        send_rx(8'hC3, 1'b0, 384);
        repeat (3840) @(negedge clk);
        check_eq("rx_framing", rx_data_o, last_rx);

        // Randomized RX frames: divisor, byte, stop bit and gap all random
        for (int i = 0; i < 8; i++) begin
            ubrr = 12'($urandom_range(0, 5));
            p = 16 * (int'(ubrr) + 1);
            b = 8'($urandom);
            while (b == last_rx) b = 8'($urandom);
            stop = ($urandom_range(0, 3) != 0);
            send_rx(b, stop, p);
            check_eq("rnd_pending", rx_exp_q.size(), 0);
            check_eq("rnd_data_o", rx_data_o, last_rx);
            gap = stop ? $urandom_range(0, 2) * p : 2 * p;
            repeat (gap) @(negedge clk);
        end

        // Divisor 0: 16 clk per bit, then abort mid start bit
        ubrr      = 12'd0;
        tx_mode   = 1'b1;
        tx_data   = 8'hA5;
        tx_mon_en = 1'b1;
        do_reset();
        base = tx_frames;
        n = 0;
        while (tx_frames < base + 2 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check_true("abort_frames_seen", tx_frames >= base + 2, tx_frames - base);
        n = 0;
        while (tx_txd !== 1'b0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        repeat (5) @(negedge clk);
        check_eq("abort_pre_txd", tx_txd, 1'b0);
        tx_mon_en = 1'b0;
        tx_mode   = 1'b0;
        @(negedge clk);
        check_eq("abort_txd", tx_txd, 1'b1);
        bad = 0;
        repeat (40) begin
            @(negedge clk);
            if (tx_txd !== 1'b1) bad++;
        end
        check_eq("abort_hold_bad_clks", bad, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
